ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the MIPS core. Owns the program counter, fetches each instruction from an instruction memory with variable wait states, and presents it to the instruction decoder/datapath. Consumes the decoder's next-PC select and the rs register value, and computes the next PC (sequential, branch, jump, register jump). It sits directly upstream of the control decoder.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- imem_req  out  1  fetch request; high only in FETCH
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  memory has accepted the request; imem_rdata is valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  instruction register (IR) contents, fed to decoder
- instr_valid  out  1  high in EXEC; decoder/datapath act on instr
- stall  in  1  datapath not finished; hold current instruction in EXEC
- npc_op  in  2  next-PC select from decoder: 00 PC+4, 01 branch, 10 jump, 11 register jump
- rs_data  in  32  rs register value, register-jump target
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc + 4, used by the datapath for jal/jalr link
- fault  out  1  misaligned-target halt indicator; see Configuration

## Operation
- States: IDLE, FETCH, EXEC, HALT (HALT exists only with the macro).
- IDLE: entered on reset, left unconditionally after one cycle to FETCH.
- FETCH: imem_req=1, imem_addr=pc held stable until imem_ack is sampled high. On ack, IR <= imem_rdata and the unit moves to EXEC.
- EXEC: instr_valid=1.
  - stall=1: stay in EXEC with IR and pc unchanged. npc_op is not sampled.
  - stall=0: pc <= next_pc, then go to FETCH.
- imem_ack is ignored outside FETCH.
- npc_op and rs_data are sampled only in EXEC with stall=0.
- next_pc, all arithmetic modulo 2^32:
  - 00: pc + 4.
  - 01: pc + 4 + (sign_extend(instr[15:0]) << 2).
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: rs_data.
- Branch-taken decision (Zero, beq/bne) is already folded into npc_op by the decoder. The IFU does not inspect the opcode.
- pc_plus4 is combinational from pc. pc = 32'hFFFF_FFFC gives pc_plus4 = 0 (wrap, no flag).

## Timing
- Reset values: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0. imem_addr=RESET_PC and pc_plus4=RESET_PC+4, both following pc.
- Reset asserted in any state, including mid-fetch with a request pending, takes effect at the next edge.
  - The pending request is abandoned.
  - An ack arriving in the IDLE cycle is ignored.
- Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction, FETCH then EXEC.
- Each memory wait cycle adds one cycle.
- First imem_req occurs in the 2nd cycle after the first edge with rstn=1.
- instr_valid stays high for every cycle of EXEC and falls in the cycle pc changes.
- imem_req, instr_valid and fault are decoded from state registers only; no input-to-output combinational path.

## Configuration
- ALIGN_CHECK_EN defined:
  - In EXEC with stall=0, if next_pc[1:0] != 0, the unit enters HALT instead of FETCH. pc is not updated.
  - In HALT: fault=1, imem_req=0, instr_valid=0.
  - HALT is left only by reset.
- ALIGN_CHECK_EN undefined:
  - next_pc[1:0] is forced to 2'b00 before loading pc.
  - fault is tied to 0 and no HALT state is built.

## Test plan
- Reset, then zero-wait memory returning 32'h2008_0005 at address 0 -> imem_req rises in the 2nd cycle after reset release, instr=32'h2008_0005 with instr_valid for 1 cycle; with npc_op=00, next imem_addr=4.
- imem_ack delayed 3 cycles -> imem_addr=pc stable and imem_req high for 4 cycles, instr_valid low throughout, then IR loads the acked data.
- Branch: pc=32'h10, instr[15:0]=16'hFFFE, npc_op=01 -> next pc=32'h0C. With npc_op=00 -> next pc=32'h14.
- Jump: pc=32'h0000_3004, instr=32'h0800_0C00, npc_op=10 -> next pc=32'h0000_3000. Register jump with rs_data=32'h0000_0040 -> next pc=32'h40.
- stall high 3 cycles in EXEC -> instr_valid high 3+1 cycles, pc and instr unchanged. rstn low during a pending fetch -> imem_req=0 next cycle, pc=RESET_PC.
- npc_op=11, rs_data=32'h0000_2002:
  - With ALIGN_CHECK_EN -> fault=1, imem_req stays 0, pc unchanged.
  - Without ALIGN_CHECK_EN -> next pc=32'h0000_2000, fault=0.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches through a wait-state memory port,
// holds the IR for the decoder. Define ALIGN_CHECK_EN to halt on misaligned targets.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

`ifdef ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_off    = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (npc_op)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc_plus4 + br_off;
      2'b10:   next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      default: next_pc = rs_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
`ifdef ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
`else
          pc_d    = {next_pc[31:2], 2'b00};
          state_d = FETCH;
`endif
        end
      end
`ifdef ALIGN_CHECK_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Handshake and status outputs come only from the state register.
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = ir_q;
`ifdef ALIGN_CHECK_EN
  assign fault       = (state_q == HALT);
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; inputs driven and outputs sampled on the falling edge.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [1:0]  npc_op;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  ifu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .npc_op(npc_op),
    .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Assumes FETCH; acks immediately and leaves the unit in EXEC.
  task automatic fetch_exec(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  // Assumes EXEC; retires with the given next-PC select.
  task automatic retire(input logic [1:0] op, input logic [31:0] rs);
    stall = 1'b0; npc_op = op; rs_data = rs;
    tick();
    npc_op = 2'b00; rs_data = '0;
  endtask

  task automatic goto(input logic [31:0] addr);
    fetch_exec(32'h0);
    retire(2'b11, addr);
  endtask

  task automatic test_reset();
    rstn = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    npc_op = 2'b00; rs_data = '0;
    repeat (3) tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4, 32'h4); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
  endtask

  task automatic test_zero_wait();
    // release with a spurious ack during the IDLE cycle
    rstn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL idle_ack_ignored got=%h exp=%h", instr, 32'h0); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=%h", imem_addr, 32'h0); end
    fetch_exec(32'h2008_0005);
    checks++; if (instr !== 32'h2008_0005) begin failures++; $display("FAIL zw_instr got=%h exp=%h", instr, 32'h2008_0005); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL zw_req_exec got=%b exp=0", imem_req); end
    retire(2'b00, 32'h0);
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL zw_next_addr got=%h exp=%h", imem_addr, 32'h4); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_valid_drop got=%b exp=0", instr_valid); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ws_req[%0d] got=%b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL ws_addr[%0d] got=%h exp=%h", i, imem_addr, 32'h4); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ws_valid[%0d] got=%b exp=0", i, instr_valid); end
      imem_ack = (i == 3); imem_rdata = 32'h1234_5678;
      tick();
    end
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h1234_5678) begin failures++; $display("FAIL ws_instr got=%h exp=%h", instr, 32'h1234_5678); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ws_valid_exec got=%b exp=1", instr_valid); end
  endtask

  task automatic test_branch();
    retire(2'b11, 32'h10);
    fetch_exec(32'h1000_FFFE);
    checks++; if (pc_plus4 !== 32'h14) begin failures++; $display("FAIL br_pc4 got=%h exp=%h", pc_plus4, 32'h14); end
    retire(2'b01, 32'h0);
    checks++; if (pc !== 32'h0C) begin failures++; $display("FAIL br_taken got=%h exp=%h", pc, 32'h0C); end
    goto(32'h10);
    fetch_exec(32'h1000_FFFE);
    retire(2'b00, 32'h0);
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL br_seq got=%h exp=%h", pc, 32'h14); end
  endtask

  task automatic test_jump();
    goto(32'h0000_3004);
    fetch_exec(32'h0800_0C00);
    retire(2'b10, 32'h0);
    checks++; if (pc !== 32'h0000_3000) begin failures++; $display("FAIL jump got=%h exp=%h", pc, 32'h3000); end
    fetch_exec(32'h0);
    retire(2'b11, 32'h0000_0040);
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL jr got=%h exp=%h", pc, 32'h40); end
  endtask

  task automatic test_stall();
    fetch_exec(32'hAAAA_5555);
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL st_valid[%0d] got=%b exp=1", i, instr_valid); end
      checks++; if (pc !== 32'h40) begin failures++; $display("FAIL st_pc[%0d] got=%h exp=%h", i, pc, 32'h40); end
      checks++; if (instr !== 32'hAAAA_5555) begin failures++; $display("FAIL st_instr[%0d] got=%h exp=%h", i, instr, 32'hAAAA_5555); end
      stall = (i < 3); npc_op = (i < 3) ? 2'b10 : 2'b00;
      imem_ack = (i < 3); imem_rdata = 32'hFFFF_FFFF;
      tick();
    end
    stall = 1'b0; imem_ack = 1'b0; npc_op = 2'b00;
    checks++; if (pc !== 32'h44) begin failures++; $display("FAIL st_after_pc got=%h exp=%h", pc, 32'h44); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL st_after_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=%h", pc_plus4, 32'h0); end
    fetch_exec(32'h0);
    retire(2'b00, 32'h0);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_reset_midfetch();
    goto(32'h80);
    rstn = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%b exp=0", imem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mid_rst_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL mid_rst_instr got=%h exp=%h", instr, 32'h0); end
    rstn = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_rst_refetch got=%b exp=1", imem_req); end
  endtask

  task automatic test_misalign();
    goto(32'h24);
    fetch_exec(32'h0);
    retire(2'b11, 32'h0000_2002);
`ifdef ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL ma_fault[%0d] got=%b exp=1", i, fault); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ma_req[%0d] got=%b exp=0", i, imem_req); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ma_valid[%0d] got=%b exp=0", i, instr_valid); end
      checks++; if (pc !== 32'h24) begin failures++; $display("FAIL ma_pc[%0d] got=%h exp=%h", i, pc, 32'h24); end
      imem_ack = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
`else
    checks++; if (pc !== 32'h2000) begin failures++; $display("FAIL ma_pc got=%h exp=%h", pc, 32'h2000); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL ma_fault got=%b exp=0", fault); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ma_req got=%b exp=1", imem_req); end
`endif
  endtask

  initial begin
    tick();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_reset_midfetch();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
